// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boot-time Avalon-MM reader that checks system ID and build timestamp against expected constants
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h53A09A30,
  parameter int          CHECK_TS       = 1,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;
  localparam logic [2:0]  LAT_M1 = 3'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
  localparam logic [15:0] TO_M1  = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          LAT0   = (READ_LATENCY == 0);
  localparam bit          DO_TS  = (CHECK_TS != 0);
  state_t      r_state, w_next, w_id_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_lat;
  logic        r_id_cap, r_ts_cap, r_done, r_pass, r_id_ok, r_ts_ok, r_timeout;
  logic [31:0] r_id_value, r_ts_value;
  logic        w_acc, w_to, w_start, w_in_rd, w_cap_id, w_cap_ts, w_to_fire, w_enter, w_id_ok, w_ts_ok;
  assign avm_read    = (r_state == RD_ID) || (r_state == RD_TS);
  assign avm_address = (r_state == RD_TS) || (r_state == LAT_TS);
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign w_acc       = avm_read & ~avm_waitrequest;
  assign w_to        = (r_cnt == TO_M1);
  assign w_start     = (r_state == IDLE) & start;
  assign w_in_rd     = (r_state == RD_ID) || (r_state == LAT_ID) || (r_state == RD_TS) || (r_state == LAT_TS);
  // a capture on the timeout cycle still counts, so timeout only fires when nothing is captured
  assign w_cap_id    = ((r_state == RD_ID) && w_acc && LAT0) || ((r_state == LAT_ID) && (r_lat == LAT_M1));
  assign w_cap_ts    = ((r_state == RD_TS) && w_acc && LAT0) || ((r_state == LAT_TS) && (r_lat == LAT_M1));
  assign w_to_fire   = w_in_rd & w_to & ~w_cap_id & ~w_cap_ts;
  assign w_enter     = (w_next != r_state) && ((w_next == RD_ID) || (w_next == RD_TS));
  assign w_id_next   = DO_TS ? RD_TS : FIN;
  assign w_id_ok     = r_id_cap && (r_id_value == EXPECTED_ID);
  assign w_ts_ok     = !DO_TS || (r_ts_cap && (r_ts_value == EXPECTED_TS));
  // state register; reset drops the read strobe immediately since it decodes from state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // next-state: capture beats timeout, timeout beats entering the latency wait
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RD_ID : IDLE;
      RD_ID:   w_next = w_cap_id ? w_id_next : w_to ? FIN : w_acc ? LAT_ID : RD_ID;
      LAT_ID:  w_next = w_cap_id ? w_id_next : w_to ? FIN : LAT_ID;
      RD_TS:   w_next = (w_cap_ts || w_to) ? FIN : w_acc ? LAT_TS : RD_TS;
      LAT_TS:  w_next = (w_cap_ts || w_to) ? FIN : LAT_TS;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // counters, captured words and sticky status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_lat      <= '0;
      r_id_cap   <= 1'b0;
      r_ts_cap   <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_cnt  <= w_enter ? '0 : w_in_rd ? r_cnt + 16'd1 : r_cnt;
      r_lat  <= w_acc ? '0 : r_lat + 3'd1;
      r_done <= (r_state == FIN);
      if (w_start) begin
        r_id_cap  <= 1'b0;
        r_ts_cap  <= 1'b0;
        r_pass    <= 1'b0;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= avm_readdata;
        r_id_cap   <= 1'b1;
      end
      if (w_cap_ts) begin
        r_ts_value <= avm_readdata;
        r_ts_cap   <= 1'b1;
      end
      if (w_to_fire) r_timeout <= 1'b1;
      if (r_state == FIN) begin
        r_id_ok <= w_id_ok;
        r_ts_ok <= w_ts_ok;
        r_pass  <= w_id_ok & w_ts_ok & ~r_timeout;
      end
    end
  end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed checks of the sysid checker against simple slave models
module tb_sysid_check_ctrl;
  logic clock = 1'b0, reset_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic addr0, read0, wr0, busy0, done0, pass0, idok0, tsok0, to0;
  logic addr1, read1, busy1, done1, pass1, idok1, tsok1, to1;
  logic [31:0] rd0, rd1, idv0, tsv0, idv1, tsv1;
  logic [31:0] id_w0 = 32'hACD51302, ts_w0 = 32'h53A09A30, id_w1 = 32'hACD51302;
  int wait_n = 0, wcnt = 0, errors = 0, checks = 0, n, rc, dc;
  bit un;
  logic [1:0] sh = 2'b00;
  bit a1seen = 1'b0;
  always #5 clock = ~clock;
  // slave 0: combinational data, waitrequest held for wait_n cycles per read
  assign wr0 = (wcnt < wait_n);
  assign rd0 = addr0 ? ts_w0 : id_w0;
  always @(posedge clock) wcnt <= (!read0 || !wr0) ? 0 : wcnt + 1;
  // slave 1: data valid only two cycles after acceptance, garbage otherwise
  assign rd1 = sh[1] ? id_w1 : 32'hDEADBEEF;
  always @(posedge clock) sh <= {sh[0], read1};
  always @(posedge clock) a1seen <= a1seen | (read1 & addr1);
  sysid_check_ctrl #(.TIMEOUT_CYCLES(8)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .avm_address(addr0), .avm_read(read0),
    .avm_waitrequest(wr0), .avm_readdata(rd0), .busy(busy0), .done(done0), .pass(pass0),
    .id_ok(idok0), .ts_ok(tsok0), .timeout(to0), .id_value(idv0), .ts_value(tsv0));
  sysid_check_ctrl #(.READ_LATENCY(2), .CHECK_TS(0)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .avm_address(addr1), .avm_read(read1),
    .avm_waitrequest(1'b0), .avm_readdata(rd1), .busy(busy1), .done(done1), .pass(pass1),
    .id_ok(idok1), .ts_ok(tsok1), .timeout(to1), .id_value(idv1), .ts_value(tsv1));
  // pulse start, optionally re-pulse at samples x1/x2, run until done or budget expires
  task automatic run(input bit sel, input int x1, input int x2);
    logic pr, pw, pa, r, a, d;
    n = 0; rc = 0; dc = 0; un = 0; pr = 0; pw = 0; pa = 0; d = 0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    do begin
      @(posedge clock); #1;
      n++;
      start0 = !sel && (n == x1 || n == x2);
      start1 = sel && (n == x1 || n == x2);
      r = sel ? read1 : read0;
      a = sel ? addr1 : addr0;
      d = sel ? done1 : done0;
      if (pr && pw && (!r || a != pa)) un = 1;
      rc += int'(r);
      dc += int'(d);
      pr = r; pw = sel ? 1'b0 : wr0; pa = a;
    end while (!d && n < 200);
    start0 = 1'b0; start1 = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({addr0, read0, busy0, done0, pass0, idok0, tsok0, to0, idv0, tsv0} !== 72'd0) begin errors++; $display("FAIL reset_u0 got=%h exp=0", {addr0, read0, busy0, done0, pass0, idok0, tsok0, to0, idv0, tsv0}); end
    checks++; if ({addr1, read1, busy1, done1, pass1, idok1, tsok1, to1, idv1, tsv1} !== 72'd0) begin errors++; $display("FAIL reset_u1 got=%h exp=0", {addr1, read1, busy1, done1, pass1, idok1, tsok1, to1, idv1, tsv1}); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask
  task automatic test_basic;
    wait_n = 0; id_w0 = 32'hACD51302;
    run(0, 0, 0);
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_done_cycles got=%0d exp=4", n); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL basic_read_cycles got=%0d exp=2", rc); end
    checks++; if ({pass0, idok0, tsok0, to0} !== 4'b1110) begin errors++; $display("FAIL basic_flags got=%b exp=1110", {pass0, idok0, tsok0, to0}); end
    checks++; if ({idv0, tsv0} !== {32'hACD51302, 32'h53A09A30}) begin errors++; $display("FAIL basic_values got=%h exp=acd5130253a09a30", {idv0, tsv0}); end
    @(posedge clock); #1;
    checks++; if ({done0, busy0} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse got=%b exp=00", {done0, busy0}); end
  endtask
  task automatic test_back_to_back;
    run(0, 0, 0);
    checks++; if (n !== 4 || {pass0, idok0, tsok0, to0} !== 4'b1110) begin errors++; $display("FAIL b2b got n=%0d flags=%b exp n=4 flags=1110", n, {pass0, idok0, tsok0, to0}); end
  endtask
  task automatic test_id_mismatch;
    id_w0 = 32'h00000001;
    run(0, 0, 0);
    checks++; if ({pass0, idok0, tsok0, to0} !== 4'b0010) begin errors++; $display("FAIL mismatch_flags got=%b exp=0010", {pass0, idok0, tsok0, to0}); end
    checks++; if (idv0 !== 32'h00000001) begin errors++; $display("FAIL mismatch_idv got=%h exp=00000001", idv0); end
    id_w0 = 32'hACD51302;
  endtask
  task automatic test_waitreq;
    wait_n = 5;
    run(0, 0, 0);
    checks++; if (n !== 14) begin errors++; $display("FAIL wait_done_cycles got=%0d exp=14", n); end
    checks++; if (rc !== 12) begin errors++; $display("FAIL wait_read_cycles got=%0d exp=12", rc); end
    checks++; if (un !== 1'b0) begin errors++; $display("FAIL wait_stable got=%b exp=0", un); end
    checks++; if ({pass0, idok0, tsok0, to0} !== 4'b1110) begin errors++; $display("FAIL wait_flags got=%b exp=1110", {pass0, idok0, tsok0, to0}); end
  endtask
  task automatic test_timeout;
    wait_n = 7;
    run(0, 0, 0);
    checks++; if (n !== 18 || {pass0, idok0, tsok0, to0} !== 4'b1110) begin errors++; $display("FAIL to_boundary got n=%0d flags=%b exp n=18 flags=1110", n, {pass0, idok0, tsok0, to0}); end
    wait_n = 255;
    run(0, 0, 0);
    checks++; if (n !== 10) begin errors++; $display("FAIL to_done_cycles got=%0d exp=10", n); end
    checks++; if (rc !== 8) begin errors++; $display("FAIL to_read_cycles got=%0d exp=8", rc); end
    checks++; if ({pass0, idok0, tsok0, to0} !== 4'b0001) begin errors++; $display("FAIL to_flags got=%b exp=0001", {pass0, idok0, tsok0, to0}); end
    wait_n = 0;
    run(0, 0, 0);
    checks++; if (n !== 4 || {pass0, idok0, tsok0, to0} !== 4'b1110) begin errors++; $display("FAIL to_recover got n=%0d flags=%b exp n=4 flags=1110", n, {pass0, idok0, tsok0, to0}); end
  endtask
  task automatic test_latency;
    run(1, 0, 0);
    checks++; if (n !== 5) begin errors++; $display("FAIL lat_done_cycles got=%0d exp=5", n); end
    checks++; if (rc !== 1) begin errors++; $display("FAIL lat_read_cycles got=%0d exp=1", rc); end
    checks++; if ({pass1, idok1, tsok1, to1} !== 4'b1110) begin errors++; $display("FAIL lat_flags got=%b exp=1110", {pass1, idok1, tsok1, to1}); end
    checks++; if ({idv1, tsv1} !== {32'hACD51302, 32'h0}) begin errors++; $display("FAIL lat_values got=%h exp=acd5130200000000", {idv1, tsv1}); end
    checks++; if (a1seen !== 1'b0) begin errors++; $display("FAIL lat_addr1 got=%b exp=0", a1seen); end
  endtask
  task automatic test_start_busy;
    int act;
    wait_n = 5; act = 0;
    run(0, 3, 13);
    checks++; if (n !== 14 || rc !== 12) begin errors++; $display("FAIL busy_start got n=%0d rc=%0d exp n=14 rc=12", n, rc); end
    repeat (6) begin
      @(posedge clock); #1;
      act += int'(read0) + int'(done0) + int'(busy0);
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL busy_no_extra got=%0d exp=0", act); end
    wait_n = 0;
  endtask
  task automatic test_reset_mid;
    wait_n = 5;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
    @(posedge clock); #1;
    checks++; if ({busy1, read1, read0} !== 3'b101) begin errors++; $display("FAIL mid_pre got=%b exp=101", {busy1, read1, read0}); end
    reset_n = 1'b0;
    #1;
    checks++; if (read0 !== 1'b0) begin errors++; $display("FAIL mid_read_async got=%b exp=0", read0); end
    checks++; if ({addr1, read1, busy1, done1, pass1, idok1, tsok1, to1, idv1, tsv1} !== 72'd0) begin errors++; $display("FAIL mid_reset_u1 got=%h exp=0", {addr1, read1, busy1, done1, pass1, idok1, tsok1, to1, idv1, tsv1}); end
    @(posedge clock); #1;
    reset_n = 1'b1; wait_n = 0;
    @(posedge clock); #1;
    run(1, 0, 0);
    checks++; if (n !== 5 || {pass1, idok1, tsok1, to1} !== 4'b1110) begin errors++; $display("FAIL mid_recover got n=%0d flags=%b exp n=5 flags=1110", n, {pass1, idok1, tsok1, to1}); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_id_mismatch;
    test_waitreq;
    test_timeout;
    test_latency;
    test_start_busy;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
